execute_muldiv: RTL and testbench

//  Iterative RV64M multiply/divide unit that sits beside the EX-stage ALU.
//  It accepts one MUL*/DIV*/REM* operation (including the W forms), computes it over several cycles,
//  and raises a stall request so that IF/ID/EX hold while it is busy.
//  It returns the XLEN result, sign-extended from bit 31 for W ops, to EX/MEM.
//  It generalises the single-cycle EX datapath with a configurable width, bits processed per cycle,
//  a valid/ready handshake and a flush input.

---
 rtl/execute_muldiv.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit placed beside the EX-stage ALU.
// Multiply is shift-add into a 2*XLEN accumulator; divide is restoring.
// Both iterate on magnitudes, and a FIXUP cycle applies sign and W-form
// correction. Latency is fixed at XLEN/UNROLL+2 cycles from accept to result.
module execute_muldiv #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      md_op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            ex_stall_req_valid_o
);

  localparam int   N_ITER = XLEN / UNROLL;
  localparam int   CNT_W  = $clog2(N_ITER);
  localparam logic HAS_W  = (XLEN == 64);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic              word_r;
  logic              is_div_r;
  logic              neg_r;
  logic              div_zero_r;
  logic [XLEN-1:0]   a_ext_r;
  logic [XLEN-1:0]   addend_r;
  logic [2*XLEN-1:0] acc_r;
  logic              ready_r;
  logic              result_valid_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s;
  logic              is_w_s;
  logic              w_unsigned_s;
  logic              a_signed_s;
  logic              b_signed_s;
  logic              is_div_s;
  logic [XLEN-1:0]   a_ext_s;
  logic [XLEN-1:0]   b_ext_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              neg_s;

  logic [2*XLEN-1:0] acc_step_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN:0]     sum_s;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   raw_s;
  logic [XLEN-1:0]   fix_result_s;

  assign accept_s       = (state_r == ST_IDLE) && valid_i && !flush_i;
  assign ready_o        = ready_r;
  assign result_valid_o = result_valid_r;
  assign result_o       = result_r;

  // Next-state selection; flush aborts to IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_W'(N_ITER - 1)) begin
            state_nxt_s = ST_FIXUP;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_FIXUP: state_nxt_s = ST_DONE;
        ST_DONE: begin
          if (result_ready_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Stall request is combinational so the pipeline freezes in the issue cycle.
  always_comb begin
    ex_stall_req_valid_o = 1'b0;
    case (state_r)
      ST_IDLE:  ex_stall_req_valid_o = valid_i;
      ST_BUSY:  ex_stall_req_valid_o = 1'b1;
      ST_FIXUP: ex_stall_req_valid_o = 1'b1;
      ST_DONE:  ex_stall_req_valid_o = !result_ready_i;
      default:  ex_stall_req_valid_o = 1'b0;
    endcase
  end

  // Operand preparation at accept: W extension, signedness, magnitudes, result sign.
  always_comb begin
    is_w_s       = word_i && HAS_W;
    w_unsigned_s = (md_op_i == OP_DIVU) || (md_op_i == OP_REMU);
    is_div_s     = md_op_i[2];
    a_signed_s   = 1'b0;
    b_signed_s   = 1'b0;
    case (md_op_i)
      OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      OP_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    if (is_w_s && w_unsigned_s) begin
      a_ext_s = XLEN'(rs1_data_i[31:0]);
      b_ext_s = XLEN'(rs2_data_i[31:0]);
    end else if (is_w_s) begin
      a_ext_s = XLEN'($signed(rs1_data_i[31:0]));
      b_ext_s = XLEN'($signed(rs2_data_i[31:0]));
    end else begin
      a_ext_s = rs1_data_i;
      b_ext_s = rs2_data_i;
    end
    a_neg_s = a_signed_s && a_ext_s[XLEN-1];
    b_neg_s = b_signed_s && b_ext_s[XLEN-1];
    if (a_neg_s) begin
      a_mag_s = {XLEN{1'b0}} - a_ext_s;
    end else begin
      a_mag_s = a_ext_s;
    end
    if (b_neg_s) begin
      b_mag_s = {XLEN{1'b0}} - b_ext_s;
    end else begin
      b_mag_s = b_ext_s;
    end
    case (md_op_i)
      OP_MULH:   neg_s = a_neg_s ^ b_neg_s;
      OP_MULHSU: neg_s = a_neg_s;
      OP_DIV:    neg_s = a_neg_s ^ b_neg_s;
      OP_REM:    neg_s = a_neg_s;
      default:   neg_s = 1'b0;
    endcase
  end

  // One BUSY cycle of work: UNROLL shift-add or restoring-divide steps.
  always_comb begin
    acc_step_s = acc_r;
    rem_sh_s   = {(XLEN+1){1'b0}};
    diff_s     = {(XLEN+1){1'b0}};
    sum_s      = {(XLEN+1){1'b0}};
    for (int k = 0; k < UNROLL; k++) begin
      if (is_div_r) begin
        // Accumulator holds {remainder, dividend/quotient}; shift one bit in.
        rem_sh_s = acc_step_s[2*XLEN-1:XLEN-1];
        diff_s   = rem_sh_s - {1'b0, addend_r};
        if (!diff_s[XLEN]) begin
          acc_step_s = {diff_s[XLEN-1:0], acc_step_s[XLEN-2:0], 1'b1};
        end else begin
          acc_step_s = {acc_step_s[2*XLEN-2:0], 1'b0};
        end
      end else begin
        // Accumulator holds {partial product, remaining multiplier bits}.
        if (acc_step_s[0]) begin
          sum_s = {1'b0, acc_step_s[2*XLEN-1:XLEN]} + {1'b0, addend_r};
        end else begin
          sum_s = {1'b0, acc_step_s[2*XLEN-1:XLEN]};
        end
        acc_step_s = {sum_s, acc_step_s[XLEN-1:1]};
      end
    end
  end

  // FIXUP: sign correction, divide-by-zero override, half select, W extension.
  always_comb begin
    if (neg_r) begin
      prod_s = {(2*XLEN){1'b0}} - acc_r;
    end else begin
      prod_s = acc_r;
    end
    if (div_zero_r) begin
      quo_s = {XLEN{1'b1}};
      rem_s = a_ext_r;
    end else if (neg_r) begin
      quo_s = {XLEN{1'b0}} - acc_r[XLEN-1:0];
      rem_s = {XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN];
    end else begin
      quo_s = acc_r[XLEN-1:0];
      rem_s = acc_r[2*XLEN-1:XLEN];
    end
    case (op_r)
      OP_MUL:    raw_s = prod_s[XLEN-1:0];
      OP_MULH:   raw_s = prod_s[2*XLEN-1:XLEN];
      OP_MULHSU: raw_s = prod_s[2*XLEN-1:XLEN];
      OP_MULHU:  raw_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV:    raw_s = quo_s;
      OP_DIVU:   raw_s = quo_s;
      OP_REM:    raw_s = rem_s;
      OP_REMU:   raw_s = rem_s;
      default:   raw_s = {XLEN{1'b0}};
    endcase
    if (word_r) begin
      fix_result_s = XLEN'($signed(raw_s[31:0]));
    end else begin
      fix_result_s = raw_s;
    end
  end

  // Control state, iteration counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      ready_r        <= 1'b1;
      result_valid_r <= 1'b0;
      result_r       <= {XLEN{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      ready_r        <= (state_nxt_s == ST_IDLE);
      result_valid_r <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if ((state_r == ST_FIXUP) && (state_nxt_s == ST_DONE)) begin
        result_r <= fix_result_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  // Datapath: latch the prepared operation on accept, iterate while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= 3'd0;
      word_r     <= 1'b0;
      is_div_r   <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_r <= 1'b0;
      a_ext_r    <= {XLEN{1'b0}};
      addend_r   <= {XLEN{1'b0}};
      acc_r      <= {(2*XLEN){1'b0}};
    end else if (accept_s) begin
      op_r       <= md_op_i;
      word_r     <= is_w_s;
      is_div_r   <= is_div_s;
      neg_r      <= neg_s;
      div_zero_r <= is_div_s && (b_ext_s == {XLEN{1'b0}});
      a_ext_r    <= a_ext_s;
      if (is_div_s) begin
        addend_r <= b_mag_s;
        acc_r    <= {{XLEN{1'b0}}, a_mag_s};
      end else begin
        addend_r <= a_mag_s;
        acc_r    <= {{XLEN{1'b0}}, b_mag_s};
      end
    end else if (state_r == ST_BUSY) begin
      acc_r <= acc_step_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: three instances (UNROLL 1, 2, 4) share
// the same stimulus; each instance's result and latency are checked.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  md_op_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_data_i = 64'd0;
  logic [63:0] rs2_data_i = 64'd0;
  logic        flush_i = 1'b0;
  logic        result_ready_i = 1'b1;

  logic [2:0]  rdy_s;
  logic [2:0]  rv_s;
  logic [2:0]  stall_s;
  logic [63:0] res_s [3];

  int compared = 0;
  int mismatched = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(64), .UNROLL(1)) u_u1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_s[0]),
    .md_op_i(md_op_i), .word_i(word_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .flush_i(flush_i), .result_valid_o(rv_s[0]),
    .result_ready_i(result_ready_i), .result_o(res_s[0]),
    .ex_stall_req_valid_o(stall_s[0]));

  execute_muldiv #(.XLEN(64), .UNROLL(2)) u_u2 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_s[1]),
    .md_op_i(md_op_i), .word_i(word_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .flush_i(flush_i), .result_valid_o(rv_s[1]),
    .result_ready_i(result_ready_i), .result_o(res_s[1]),
    .ex_stall_req_valid_o(stall_s[1]));

  execute_muldiv #(.XLEN(64), .UNROLL(4)) u_u4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_s[2]),
    .md_op_i(md_op_i), .word_i(word_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .flush_i(flush_i), .result_valid_o(rv_s[2]),
    .result_ready_i(result_ready_i), .result_o(res_s[2]),
    .ex_stall_req_valid_o(stall_s[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation to all instances and check result and latency of each.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    logic [2:0] seen;
    int lat [3];
    int exp_lat [3];
    exp_lat[0] = 66; exp_lat[1] = 34; exp_lat[2] = 18;
    seen = 3'b000;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    result_ready_i = 1'b1;
    check({tag, " ready_before"}, 64'(rdy_s), 64'h7);
    valid_i = 1'b1; md_op_i = op; word_i = w; rs1_data_i = a; rs2_data_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check({tag, " busy_stall"}, 64'(stall_s), 64'h7);
    check({tag, " busy_ready"}, 64'(rdy_s), 64'h0);
    for (int cyc = 1; cyc <= 80 && seen != 3'b111; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && rv_s[i]) begin
          seen[i] = 1'b1;
          lat[i] = cyc;
          check($sformatf("%s u%0d result", tag, i), res_s[i], exp);
        end
      end
      if (seen != 3'b111) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("%s u%0d latency", tag, i), 64'(lat[i]), 64'(exp_lat[i]));
    @(posedge clk); #1;
  endtask

  // Directed test sequence.
  initial begin
    logic       rv_seen;
    logic [63:0] exp_v;

    // Reset values
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset ready", 64'(rdy_s), 64'h7);
    check("reset valid", 64'(rv_s), 64'h0);
    check("reset stall", 64'(stall_s), 64'h0);
    check("reset result", res_s[0] | res_s[1] | res_s[2], 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Stall is combinational on a request in IDLE
    valid_i = 1'b1; flush_i = 1'b1; md_op_i = 3'd0;
    #1;
    check("idle req stall", 64'(stall_s), 64'h7);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush blocks accept", 64'(rdy_s), 64'h7);
    @(posedge clk); #1;
    check("flush blocks accept later", 64'(rv_s | stall_s), 64'h0);

    run_op("MUL 7*-3",        3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("MULHU ones",      3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("MULH ones",       3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run_op("MULHSU -1*2",     3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("DIV -7/2",        3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("REM -7/2",        3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("DIVW ovf",        3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run_op("REMW ovf",        3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run_op("DIV ovf64",       3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    run_op("DIVU by0",        3'd5, 1'b0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("REMU by0",        3'd7, 1'b0, 64'h1234, 64'h0, 64'h1234);
    run_op("DIV -5/0",        3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("DIVU 100/7",      3'd5, 1'b0, 64'd100, 64'd7, 64'd14);

    // Back-pressure: hold result_ready_i low after the results appear
    result_ready_i = 1'b0;
    valid_i = 1'b1; md_op_i = 3'd0; word_i = 1'b0;
    rs1_data_i = 64'd7; rs2_data_i = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_v = 64'hFFFF_FFFF_FFFF_FFEB;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 0; c < 80 && rv_s != 3'b111; c++) begin
      @(posedge clk); #1;
    end
    check("bp all valid", 64'(rv_s), 64'h7);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d valid", c), 64'(rv_s), 64'h7);
      check($sformatf("bp hold%0d stall", c), 64'(stall_s), 64'h7);
      for (int i = 0; i < 3; i++)
        check($sformatf("bp hold%0d u%0d result", c, i), res_s[i], exp_v);
      @(posedge clk); #1;
    end
    result_ready_i = 1'b1;
    #1;
    check("bp release stall", 64'(stall_s), 64'h0);
    @(posedge clk); #1;
    check("bp idle ready", 64'(rdy_s), 64'h7);
    check("bp idle valid", 64'(rv_s), 64'h0);

    // Flush in cycle 10 of BUSY
    valid_i = 1'b1; md_op_i = 3'd5; word_i = 1'b0;
    rs1_data_i = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data_i = 64'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("flush pre busy", 64'(rdy_s), 64'h0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush ready", 64'(rdy_s), 64'h7);
    check("flush valid", 64'(rv_s), 64'h0);
    rv_seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      rv_seen = rv_seen | (|rv_s);
      @(posedge clk); #1;
    end
    check("flush no result", 64'(rv_seen), 64'h0);
    run_op("MULW after flush", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
